oflow_score_board: RTL and testbench

Frame-level match arbiter directly downstream of the score-calculation stage. For each current-frame object it captures the best and second-best previous-frame candidates (score, id) delivered with `done_score_calc`. On request it resolves them into one final, unique id per object, allocating fresh ids where no candidate survives. Final ids stream out in object-index order to the registration / write-back logic.

---
 rtl/oflow_score_board_pkg.sv | 41 ++++
 rtl/oflow_score_board_new_id_gen.sv | 16 +
 rtl/oflow_score_board.sv | 171 +++++++++++++++++
 tb/tb_oflow_score_board.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/oflow_score_board_pkg.sv
// Shared types and widths for the frame-level score board.
// SCORE_LEN / ID_LEN are taken from the core defines when present.
`ifndef SCORE_LEN
`define SCORE_LEN 8
`endif
`ifndef ID_LEN
`define ID_LEN 8
`endif

package oflow_score_board_pkg;

  localparam int unsigned SCORE_W = `SCORE_LEN;
  localparam int unsigned ID_W    = `ID_LEN;
  localparam int unsigned MAX_OBJ = 16;
  localparam int unsigned IDX_W   = $clog2(MAX_OBJ);
  localparam int unsigned CNT_W   = IDX_W + 1;

  localparam logic [ID_W-1:0] NO_ID = '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [SCORE_W-1:0] score0;
    logic [ID_W-1:0]    id0;
    logic [SCORE_W-1:0] score1;
    logic [ID_W-1:0]    id1;
  } entry_t;

  // Successor id that skips NO_ID on wrap.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == '1) next_id = ID_W'(1);
    else          next_id = id + ID_W'(1);
  endfunction

endpackage

// File: rtl/oflow_score_board_new_id_gen.sv
// Fresh-id generator: starts at 1, persists across frames, never yields 0.
module oflow_score_board_new_id_gen
  import oflow_score_board_pkg::*;
(
  input  logic            clk,
  input  logic            reset_N,
  input  logic            alloc,
  output logic [ID_W-1:0] new_id
);

  always_ff @(posedge clk) begin
    if (!reset_N)   new_id <= ID_W'(1);
    else if (alloc) new_id <= next_id(new_id);
  end

endmodule

// File: rtl/oflow_score_board.sv
// Match arbiter: captures best/second candidates per object, then resolves
// unique final ids in index order. Optional macro OFLOW_SCORE_BOARD_THRESHOLD_EN
// adds the score <= score_threshold test to candidate usability.
module oflow_score_board
  import oflow_score_board_pkg::*;
(
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start_score_board,
  input  logic               done_score_calc,
  input  logic [IDX_W-1:0]   obj_idx,
  input  logic [SCORE_W-1:0] min_score_0,
  input  logic [ID_W-1:0]    min_id_0,
  input  logic [SCORE_W-1:0] min_score_1,
  input  logic [ID_W-1:0]    min_id_1,
  input  logic [SCORE_W-1:0] score_threshold,
  input  logic               start_resolve,
  input  logic [CNT_W-1:0]   num_objects,
  output logic               final_valid,
  output logic [IDX_W-1:0]   final_obj_idx,
  output logic [ID_W-1:0]    final_id,
  output logic               final_is_new,
  output logic               done_score_board,
  output logic               busy
);

  state_t             state_q, state_d;
  entry_t             tbl_q [MAX_OBJ];
  logic [MAX_OBJ-1:0] asg_vld_q;
  logic [ID_W-1:0]    asg_id_q [MAX_OBJ];
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   idx_q;
  logic [ID_W-1:0]    new_id;

  logic [CNT_W-1:0]   num_clamp_c;
  logic               idx_ok_c;
  logic               accept_resolve_c;
  logic               last_c;
  logic               resolving_c;
  logic               alloc_c;
  entry_t             cur_c;
  logic               claimed0_c, claimed1_c;
  logic               ok0_c, ok1_c;
  logic [ID_W-1:0]    sel_id_c;
  logic               sel_new_c;

  // Index range guard only matters when MAX_OBJ is not a power of two.
  if ((1 << IDX_W) > MAX_OBJ) begin : g_idx_chk
    assign idx_ok_c = 32'(obj_idx) < MAX_OBJ;
  end else begin : g_idx_full
    assign idx_ok_c = 1'b1;
  end

  assign num_clamp_c      = (num_objects > CNT_W'(MAX_OBJ)) ? CNT_W'(MAX_OBJ) : num_objects;
  assign accept_resolve_c = (state_q == S_COLLECT) && start_resolve && !start_score_board;
  assign last_c           = (idx_q == num_q - CNT_W'(1));
  assign resolving_c      = (state_q == S_RESOLVE) && !start_score_board;
  assign alloc_c          = resolving_c && sel_new_c;

  always_ff @(posedge clk) begin
    if (!reset_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the per-entry candidate decision.
  always_comb begin
    state_d    = state_q;
    cur_c      = tbl_q[idx_q[IDX_W-1:0]];
    claimed0_c = 1'b0;
    claimed1_c = 1'b0;
    sel_id_c   = new_id;
    sel_new_c  = 1'b1;

    for (int j = 0; j < MAX_OBJ; j++) begin
      if (asg_vld_q[j] && (asg_id_q[j] == cur_c.id0)) claimed0_c = 1'b1;
      if (asg_vld_q[j] && (asg_id_q[j] == cur_c.id1)) claimed1_c = 1'b1;
    end

    ok0_c = cur_c.valid && (cur_c.id0 != NO_ID) && !claimed0_c;
    ok1_c = cur_c.valid && (cur_c.id1 != NO_ID) && !claimed1_c;
`ifdef OFLOW_SCORE_BOARD_THRESHOLD_EN
    ok0_c = ok0_c && (cur_c.score0 <= score_threshold);
    ok1_c = ok1_c && (cur_c.score1 <= score_threshold);
`endif

    if (ok0_c) begin
      sel_id_c  = cur_c.id0;
      sel_new_c = 1'b0;
    end else if (ok1_c) begin
      sel_id_c  = cur_c.id1;
      sel_new_c = 1'b0;
    end

    case (state_q)
      S_IDLE:    if (start_score_board) state_d = S_COLLECT;
      S_COLLECT: begin
        // An empty frame has nothing to resolve and finishes straight away.
        if (start_score_board)  state_d = S_COLLECT;
        else if (start_resolve) state_d = (num_clamp_c == '0) ? S_DONE : S_RESOLVE;
      end
      S_RESOLVE: begin
        if (start_score_board) state_d = S_COLLECT;
        else if (last_c)       state_d = S_DONE;
      end
      S_DONE:    state_d = start_score_board ? S_COLLECT : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifndef OFLOW_SCORE_BOARD_THRESHOLD_EN
  logic unused_score;
  assign unused_score = ^{score_threshold, cur_c.score0, cur_c.score1};
`endif

  // Candidate table; a new frame or abort clears the valid bits.
  always_ff @(posedge clk) begin
    if (!reset_N || start_score_board) begin
      for (int i = 0; i < MAX_OBJ; i++) tbl_q[i].valid <= 1'b0;
    end else if ((state_q == S_COLLECT) && done_score_calc && idx_ok_c) begin
      tbl_q[obj_idx] <= '{valid: 1'b1, score0: min_score_0, id0: min_id_0,
                          score1: min_score_1, id1: min_id_1};
    end
  end

  // Ids already handed out this frame, plus the resolve walk pointer.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      asg_vld_q <= '0;
      num_q     <= '0;
      idx_q     <= '0;
    end else if (start_score_board) begin
      asg_vld_q <= '0;
    end else if (accept_resolve_c) begin
      asg_vld_q <= '0;
      num_q     <= num_clamp_c;
      idx_q     <= '0;
    end else if (state_q == S_RESOLVE) begin
      asg_vld_q[idx_q[IDX_W-1:0]] <= 1'b1;
      asg_id_q[idx_q[IDX_W-1:0]]  <= sel_id_c;
      idx_q                       <= idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_N) begin
      final_valid      <= 1'b0;
      final_obj_idx    <= '0;
      final_id         <= '0;
      final_is_new     <= 1'b0;
      done_score_board <= 1'b0;
      busy             <= 1'b0;
    end else begin
      final_valid      <= resolving_c;
      done_score_board <= (state_q == S_DONE) && !start_score_board;
      busy             <= (state_d == S_RESOLVE) || (state_d == S_DONE);
      if (resolving_c) begin
        final_obj_idx <= idx_q[IDX_W-1:0];
        final_id      <= sel_id_c;
        final_is_new  <= sel_new_c;
      end
    end
  end

  oflow_score_board_new_id_gen u_new_id_gen (
    .clk     (clk),
    .reset_N (reset_N),
    .alloc   (alloc_c),
    .new_id  (new_id)
  );

endmodule

// File: tb/tb_oflow_score_board.sv
// Directed self-checking bench for oflow_score_board.
module tb_oflow_score_board;
  import oflow_score_board_pkg::*;

  logic               clk = 1'b0;
  logic               reset_N;
  logic               start_score_board;
  logic               done_score_calc;
  logic [IDX_W-1:0]   obj_idx;
  logic [SCORE_W-1:0] min_score_0, min_score_1, score_threshold;
  logic [ID_W-1:0]    min_id_0, min_id_1;
  logic               start_resolve;
  logic [CNT_W-1:0]   num_objects;
  logic               final_valid;
  logic [IDX_W-1:0]   final_obj_idx;
  logic [ID_W-1:0]    final_id;
  logic               final_is_new;
  logic               done_score_board;
  logic               busy;

  int tests = 0;
  int fails = 0;
  int exp_next = 1;
  localparam int MAX_ID = (1 << ID_W) - 1;

  oflow_score_board dut (
    .clk(clk), .reset_N(reset_N), .start_score_board(start_score_board),
    .done_score_calc(done_score_calc), .obj_idx(obj_idx),
    .min_score_0(min_score_0), .min_id_0(min_id_0),
    .min_score_1(min_score_1), .min_id_1(min_id_1),
    .score_threshold(score_threshold), .start_resolve(start_resolve),
    .num_objects(num_objects), .final_valid(final_valid),
    .final_obj_idx(final_obj_idx), .final_id(final_id),
    .final_is_new(final_is_new), .done_score_board(done_score_board),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int id);
    return (id == MAX_ID) ? 1 : id + 1;
  endfunction

  task automatic pulse_start();
    start_score_board = 1'b1;
    tick();
    start_score_board = 1'b0;
  endtask

  task automatic write_entry(input int idx, input int s0, input int i0, input int s1, input int i1);
    obj_idx = IDX_W'(idx);
    min_score_0 = SCORE_W'(s0); min_id_0 = ID_W'(i0);
    min_score_1 = SCORE_W'(s1); min_id_1 = ID_W'(i1);
    done_score_calc = 1'b1;
    tick();
    done_score_calc = 1'b0;
  endtask

  task automatic issue_resolve(input int n);
    num_objects = CNT_W'(n);
    start_resolve = 1'b1;
    tick();
    start_resolve = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int k, input int id, input int is_new);
    tick();
    chk({tag, "_valid"}, 32'(final_valid), 32'd1);
    chk({tag, "_idx"}, 32'(final_obj_idx), 32'(k));
    chk({tag, "_id"}, 32'(final_id), 32'(id));
    chk({tag, "_new"}, 32'(final_is_new), 32'(is_new));
  endtask

  // Resolve n_req objects that all fall back to fresh ids; n_exp is the clamped count.
  task automatic resolve_new(input string tag, input int n_req, input int n_exp);
    issue_resolve(n_req);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < n_exp; k++) begin
      expect_out(tag, k, exp_next, 1);
      exp_next = model_next(exp_next);
    end
    tick();
    chk({tag, "_done"}, 32'(done_score_board), 32'd1);
    chk({tag, "_valid_end"}, 32'(final_valid), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_N = 1'b0; start_score_board = 1'b0; done_score_calc = 1'b0;
    obj_idx = '0; min_score_0 = '0; min_id_0 = '0; min_score_1 = '0; min_id_1 = '0;
    score_threshold = '0; start_resolve = 1'b0; num_objects = '0;
    tick(); tick();
    chk("rst_valid", 32'(final_valid), 32'd0);
    chk("rst_idx", 32'(final_obj_idx), 32'd0);
    chk("rst_id", 32'(final_id), 32'd0);
    chk("rst_new", 32'(final_is_new), 32'd0);
    chk("rst_done", 32'(done_score_board), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_N = 1'b1;
    tick();

    // start_resolve in IDLE is ignored
    issue_resolve(2);
    chk("idle_resolve_busy", 32'(busy), 32'd0);
    tick();
    chk("idle_resolve_valid", 32'(final_valid), 32'd0);

    // Basic accept
    score_threshold = SCORE_W'(100);
    pulse_start();
    write_entry(0, 30, 5, 60, 7);
    write_entry(1, 40, 9, 50, 3);
    issue_resolve(2);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_pre_valid", 32'(final_valid), 32'd0);
    expect_out("basic0", 0, 5, 0);
    expect_out("basic1", 1, 9, 0);
    tick();
    chk("basic_done", 32'(done_score_board), 32'd1);
    chk("basic_busy_end", 32'(busy), 32'd0);
    tick();
    chk("basic_done_pulse", 32'(done_score_board), 32'd0);

    // Conflict: lower index keeps id 5, idx1 falls back to its second candidate
    pulse_start();
    write_entry(0, 10, 5, 30, 7);
    write_entry(1, 5, 5, 20, 8);
    issue_resolve(2);
    expect_out("conf0", 0, 5, 0);
    expect_out("conf1", 1, 8, 0);
    tick();
    chk("conf_done", 32'(done_score_board), 32'd1);

    // Threshold reject; overwrite of idx0 and write coincident with start_resolve
    score_threshold = SCORE_W'(50);
    pulse_start();
    write_entry(0, 1, 9, 1, 9);
    obj_idx = '0;
    min_score_0 = SCORE_W'(80); min_id_0 = ID_W'(4);
    min_score_1 = SCORE_W'(90); min_id_1 = ID_W'(6);
    done_score_calc = 1'b1;
    issue_resolve(1);
    done_score_calc = 1'b0;
`ifdef OFLOW_SCORE_BOARD_THRESHOLD_EN
    expect_out("thr", 0, exp_next, 1);
    exp_next = model_next(exp_next);
`else
    expect_out("thr", 0, 4, 0);
`endif
    tick();
    chk("thr_done", 32'(done_score_board), 32'd1);

    // Empty frame
    pulse_start();
    issue_resolve(0);
    chk("n0_busy", 32'(busy), 32'd1);
    chk("n0_valid", 32'(final_valid), 32'd0);
    tick();
    chk("n0_done", 32'(done_score_board), 32'd1);
    chk("n0_valid2", 32'(final_valid), 32'd0);
    chk("n0_busy_end", 32'(busy), 32'd0);

    // Abort mid-resolve after three outputs
    score_threshold = SCORE_W'(100);
    pulse_start();
    write_entry(3, 1, 200, 1, 201);
    issue_resolve(8);
    for (int k = 0; k < 3; k++) begin
      expect_out("abort", k, exp_next, 1);
      exp_next = model_next(exp_next);
    end
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      chk("abort_valid", 32'(final_valid), 32'd0);
      chk("abort_done", 32'(done_score_board), 32'd0);
      tick();
    end
    chk("abort_busy", 32'(busy), 32'd0);
    // Still in COLLECT with an empty table: resolve accepted without a new start
    resolve_new("post_abort", 2, 2);

    // Clamp num_objects > MAX_OBJ, and advance the generator toward wrap
    pulse_start();
    resolve_new("clamp", 20, 16);
    while (MAX_ID - exp_next >= 16) begin
      pulse_start();
      resolve_new("pump", 16, 16);
    end
    if (MAX_ID - exp_next > 0) begin
      pulse_start();
      resolve_new("pump_tail", MAX_ID - exp_next, MAX_ID - exp_next);
    end
    pulse_start();
    issue_resolve(2);
    expect_out("wrap0", 0, MAX_ID, 1);
    expect_out("wrap1", 1, 1, 1);
    tick();
    chk("wrap_done", 32'(done_score_board), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
